sram_bus_ctrl: RTL and testbench
================================

Name: sram_bus_ctrl

Overview:
Synchronous sequencer sitting directly upstream of the 2048x8 asynchronous work SRAM model (active-low write and output strobes). Accepts single-beat read/write requests from the sound-engine/CPU side over a valid/ready handshake. Generates address, data and strobe timing with programmable setup/pulse/hold phases. Returns read data or write acknowledge on a one-cycle response strobe.

Parameters:
DATA_WIDTH, 8, SRAM data width
ADDR_WIDTH, 11, SRAM address width
SETUP_CYC, 1, cycles address/data stable before strobe (range 1..15)
PULSE_CYC, 2, cycles strobe held active (range 1..15)
HOLD_CYC, 1, cycles address/data held after strobe release (range 1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on reads
sram_addr  out  ADDR_WIDTH  SRAM address
sram_dout  out  DATA_WIDTH  data toward SRAM
sram_dout_en  out  1  top-level tristate enable for sram_dout
sram_din  in  DATA_WIDTH  data from SRAM
sram_we_n  out  1  SRAM write strobe, active low
sram_oe_n  out  1  SRAM output enable, active low
verify_err  out  1  sticky write-verify mismatch flag

Behaviour:
- Clock/reset decided: single clock clk; reset rst_n asynchronous, active-low.
- Reset values: state IDLE, sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_dout=0, sram_dout_en=0, rsp_valid=0, rsp_rdata=0, verify_err=0. All SRAM-facing outputs registered.
- req_ready = (state==IDLE), combinational from state; transfer occurs on clk edge with req_valid && req_ready. Request fields latched at transfer.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Phase down-counter loaded with phase length on entry; exit when counter reaches 1.
- SETUP: sram_addr=latched addr; write: sram_dout=wdata, sram_dout_en=1; strobes inactive.
- STROBE: write: sram_we_n=0, sram_oe_n=1; read: sram_oe_n=0, sram_we_n=1, sram_dout_en=0. Read captures sram_din into rsp_rdata on the last STROBE cycle edge.
- HOLD: both strobes high; address held; write keeps sram_dout/sram_dout_en; read dout_en stays 0.
- Exit HOLD: rsp_valid=1 for exactly one cycle, in the first IDLE cycle; req_ready is also 1 there, so back-to-back requests are legal (new SETUP begins next cycle). rsp_rdata holds its value until the next read capture; value on writes is don't-care but unchanged.
- Latency: accept edge to rsp_valid high = SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (default 4). Throughput: one transfer per SETUP+PULSE+HOLD+1 cycles.
- Invariants: sram_we_n and sram_oe_n never low simultaneously; sram_dout_en never 1 while sram_oe_n=0; sram_addr never changes while any strobe is low.
- sram_dout_en drops at IDLE entry; sram_addr retains last value in IDLE.
- Reset mid-operation: strobes deassert immediately (async); in-flight request dropped; no rsp_valid issued.
- req_valid while not ready: ignored, no side effects; requester must hold fields stable until accepted.

Optional Feature:
SRAM_BUS_CTRL_WRITE_VERIFY_EN
- Defined: after a write's HOLD, the FSM runs VSETUP/VSTROBE/VHOLD, an internal read of the same address with identical timing. Compares captured sram_din with written data; mismatch sets verify_err (sticky until reset). rsp_valid is issued after the verify read. Write latency = 2*(SETUP+PULSE+HOLD). Reads unchanged.
- Undefined: no verify states; verify_err tied 0.

Decomposition:
- Package sram_bus_ctrl_pkg: FSM state enum (IDLE, SETUP, STROBE, HOLD, VSETUP, VSTROBE, VHOLD), phase-counter width constant (4 bits), default timing constants.
- One sub-module: sram_phase_timer (loadable 4-bit down-counter with last-cycle flag), instantiated once.

Test Plan:
- Reset: assert rst_n=0 mid-STROBE of a write -> sram_we_n=1, sram_dout_en=0 same cycle; no rsp_valid after release.
- Write 0x5A to 0x123, then read 0x123 (SRAM model writes enabled) -> rsp_valid exactly 4 cycles after each accept; rsp_rdata=0x5A.
- Back-to-back reads 0x000 and 0x7FF with req_valid held -> second accept in the rsp_valid cycle of the first; address at 0x7FF boundary is correct, no strobe overlap.
- SETUP_CYC=3, PULSE_CYC=4, HOLD_CYC=2 -> sram_oe_n low exactly 4 cycles starting 3 cycles after accept; rsp_valid at cycle 9.
- Protocol monitor over 1000 random requests -> we_n/oe_n never both low; dout_en never 1 with oe_n=0; addr stable during strobes.
- With SRAM_BUS_CTRL_WRITE_VERIFY_EN, stuck-at-0 SRAM model, write 0xFF -> verify_err=1, rsp_valid at cycle 8; without the macro -> verify_err stays 0.

Source files
------------

// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types and timing constants for the SRAM bus sequencer.
package sram_bus_ctrl_pkg;

   localparam int unsigned PHASE_W       = 4;
   localparam int unsigned SETUP_CYC_DEF = 1;
   localparam int unsigned PULSE_CYC_DEF = 2;
   localparam int unsigned HOLD_CYC_DEF  = 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      VSETUP,
      VSTROBE,
      VHOLD
   } state_e;

   // SRAM-facing control strobes, all active-low except the data enable
   typedef struct packed {
      logic we_n;
      logic oe_n;
      logic dout_en;
   } strobe_t;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter; last_o is high during the final cycle of a phase.
module sram_phase_timer
   import sram_bus_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [PHASE_W-1:0] load_val_i,
   output logic               last_o
);

   logic [PHASE_W-1:0] cnt_q, cnt_d;
   logic               last_q, last_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - PHASE_W'(1);
      end
      last_d = (cnt_d == PHASE_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-beat valid/ready to async SRAM sequencer with programmable setup/pulse/hold.
// Optional write read-back check enabled by SRAM_BUS_CTRL_WRITE_VERIFY_EN.
module sram_bus_ctrl
   import sram_bus_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
   parameter int unsigned PULSE_CYC  = PULSE_CYC_DEF,
   parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_dout,
   output logic                  sram_dout_en,
   input  logic [DATA_WIDTH-1:0] sram_din,
   output logic                  sram_we_n,
   output logic                  sram_oe_n,
   output logic                  verify_err
);

   localparam logic [PHASE_W-1:0] SETUP_L = PHASE_W'(SETUP_CYC);
   localparam logic [PHASE_W-1:0] PULSE_L = PHASE_W'(PULSE_CYC);
   localparam logic [PHASE_W-1:0] HOLD_L  = PHASE_W'(HOLD_CYC);

   state_e                state_q, state_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   strobe_t               strb_q, strb_d;
`ifdef SRAM_BUS_CTRL_WRITE_VERIFY_EN
   logic                  verr_q, verr_d;
`endif

   logic                  tmr_load;
   logic [PHASE_W-1:0]    tmr_val;
   logic                  tmr_last;

   sram_phase_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .last_o     (tmr_last)
   );

   // Next-state and next-output logic; outputs are registered from these
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      addr_d       = addr_q;
      dout_d       = dout_q;
      rdata_d      = rdata_q;
      rsp_valid_d  = 1'b0;
      strb_d.we_n  = 1'b1;
      strb_d.oe_n  = 1'b1;
      strb_d.dout_en = strb_q.dout_en;
      tmr_load     = 1'b0;
      tmr_val      = SETUP_L;
`ifdef SRAM_BUS_CTRL_WRITE_VERIFY_EN
      verr_d       = verr_q;
`endif
      unique case (state_q)
         IDLE: begin
            strb_d.dout_en = 1'b0;
            if (req_valid) begin
               state_d  = SETUP;
               we_d     = req_we;
               addr_d   = req_addr;
               tmr_load = 1'b1;
               tmr_val  = SETUP_L;
               if (req_we) begin
                  dout_d         = req_wdata;
                  strb_d.dout_en = 1'b1;
               end
            end
         end
         SETUP: begin
            if (tmr_last) begin
               state_d     = STROBE;
               tmr_load    = 1'b1;
               tmr_val     = PULSE_L;
               strb_d.we_n = ~we_q;
               strb_d.oe_n = we_q;
            end
         end
         STROBE: begin
            if (tmr_last) begin
               state_d  = HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_L;
               if (!we_q) begin
                  rdata_d = sram_din;
               end
            end else begin
               strb_d.we_n = ~we_q;
               strb_d.oe_n = we_q;
            end
         end
         HOLD: begin
            if (tmr_last) begin
               strb_d.dout_en = 1'b0;
`ifdef SRAM_BUS_CTRL_WRITE_VERIFY_EN
               if (we_q) begin
                  state_d  = VSETUP;
                  tmr_load = 1'b1;
                  tmr_val  = SETUP_L;
               end else begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b1;
               end
`else
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
`endif
            end
         end
`ifdef SRAM_BUS_CTRL_WRITE_VERIFY_EN
         VSETUP: begin
            if (tmr_last) begin
               state_d     = VSTROBE;
               tmr_load    = 1'b1;
               tmr_val     = PULSE_L;
               strb_d.oe_n = 1'b0;
            end
         end
         VSTROBE: begin
            if (tmr_last) begin
               state_d  = VHOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_L;
               if (sram_din != dout_q) begin
                  verr_d = 1'b1;
               end
            end else begin
               strb_d.oe_n = 1'b0;
            end
         end
         VHOLD: begin
            if (tmr_last) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         dout_q       <= '0;
         rdata_q      <= '0;
         rsp_valid_q  <= 1'b0;
         strb_q       <= '{we_n: 1'b1, oe_n: 1'b1, dout_en: 1'b0};
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         dout_q       <= dout_d;
         rdata_q      <= rdata_d;
         rsp_valid_q  <= rsp_valid_d;
         strb_q       <= strb_d;
      end
   end

`ifdef SRAM_BUS_CTRL_WRITE_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         verr_q <= 1'b0;
      end else begin
         verr_q <= verr_d;
      end
   end
   assign verify_err = verr_q;
`else
   assign verify_err = 1'b0;
`endif

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign sram_addr    = addr_q;
   assign sram_dout    = dout_q;
   assign sram_dout_en = strb_q.dout_en;
   assign sram_we_n    = strb_q.we_n;
   assign sram_oe_n    = strb_q.oe_n;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed + random bench for sram_bus_ctrl with an SRAM model and response scoreboard.
`timescale 1ns/1ps
module tb_sram_bus_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 11;
   localparam int RLAT = 4;
`ifdef SRAM_BUS_CTRL_WRITE_VERIFY_EN
   localparam int WLAT = 8;
   localparam logic VERR_EXP = 1'b1;
`else
   localparam int WLAT = 4;
   localparam logic VERR_EXP = 1'b0;
`endif

   typedef struct {
      int         due;
      bit         chk;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          req_valid = 1'b0, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready, rsp_valid, sram_dout_en, sram_we_n, sram_oe_n, verify_err;
   logic [DW-1:0] rsp_rdata, sram_dout, sram_din;
   logic [AW-1:0] sram_addr;

   logic          b_req_valid = 1'b0;
   logic          b_req_ready, b_rsp_valid, b_dout_en, b_we_n, b_oe_n, b_verr;
   logic [DW-1:0] b_rdata, b_dout;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_din = 8'hA5;

   logic [7:0] mem [2048];
   logic [7:0] shadow [2048];
   bit         written [2048];
   bit         stuck0 = 1'b0;
   exp_t       sb[$];
   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_bus_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_addr(sram_addr),
      .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .verify_err(verify_err)
   );

   sram_bus_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) dut_slow (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(1'b0), .req_addr(11'h3C3), .req_wdata(8'h00),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .sram_addr(b_addr),
      .sram_dout(b_dout), .sram_dout_en(b_dout_en), .sram_din(b_din),
      .sram_we_n(b_we_n), .sram_oe_n(b_oe_n), .verify_err(b_verr)
   );

   // Asynchronous SRAM model, optional stuck-at-0 read path
   assign sram_din = stuck0 ? 8'h00 : mem[sram_addr];
   always @(posedge clk) begin
      if (!sram_we_n && sram_dout_en) mem[sram_addr] <= sram_dout;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request from a negedge; returns the accept edge index
   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc);
      exp_t e;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      acc = -1;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         if (req_ready) begin
            acc    = cyc + 1;
            e.due  = acc + (we ? WLAT : RLAT);
            e.chk  = !we && written[a];
            e.data = shadow[a];
            sb.push_back(e);
            if (we) begin
               shadow[a]  = d;
               written[a] = 1'b1;
            end
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("accept_timeout", 32'(acc >= 0), 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Protocol monitor and response scoreboard
   logic [AW-1:0] prev_addr;
   bit            prev_low = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check("we_oe_overlap", 32'(sram_we_n | sram_oe_n), 32'd1);
         check("dout_en_oe", 32'(!(sram_dout_en && !sram_oe_n)), 32'd1);
         if (prev_low && (!sram_we_n || !sram_oe_n))
            check("addr_stable", 32'(sram_addr), 32'(prev_addr));
         if (rsp_valid) begin
            check("rsp_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("rsp_cycle", 32'(cyc), 32'(e.due));
               if (e.chk) check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
            end
         end
         prev_low  = !sram_we_n || !sram_oe_n;
         prev_addr = sram_addr;
      end else begin
         prev_low = 1'b0;
      end
   end

   initial begin
      int a1, a2, dummy;
      logic [11:0] oe_mask, rsp_mask;
      logic [AW-1:0] ra;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe_n", 32'(sram_oe_n), 32'd1);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_dout", 32'(sram_dout), 32'd0);
      check("rst_dout_en", 32'(sram_dout_en), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_verr", 32'(verify_err), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read back
      issue(1'b1, 11'h123, 8'h5A, dummy);
      issue(1'b0, 11'h123, 8'h00, dummy);
      wait_drain();
      check("rd_5a", 32'(rsp_rdata), 32'h5A);

      // Back-to-back reads at address extremes
      issue(1'b1, 11'h000, 8'h11, dummy);
      issue(1'b1, 11'h7FF, 8'hEE, dummy);
      wait_drain();
      issue(1'b0, 11'h000, 8'h00, a1);
      issue(1'b0, 11'h7FF, 8'h00, a2);
      check("b2b_addr", 32'(sram_addr), 32'h7FF);
      check("b2b_gap", 32'(a2 - a1), 32'(RLAT + 1));
      wait_drain();
      check("rd_7ff", 32'(rsp_rdata), 32'hEE);

      // Stretched timing instance: setup 3, pulse 4, hold 2
      b_req_valid = 1'b1;
      check("slow_ready", 32'(b_req_ready), 32'd1);
      @(negedge clk);
      b_req_valid = 1'b0;
      oe_mask = '0;
      rsp_mask = '0;
      for (int k = 0; k < 12; k++) begin
         oe_mask[k]  = !b_oe_n;
         rsp_mask[k] = b_rsp_valid;
         @(negedge clk);
      end
      check("slow_oe_window", 32'(oe_mask), 32'h078);
      check("slow_rsp_cycle", 32'(rsp_mask), 32'h200);
      check("slow_rdata", 32'(b_rdata), 32'hA5);

      // Random traffic under the protocol monitor
      for (int n = 0; n < 1000; n++) begin
         ra = 11'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) ra = ra | 11'h7C0;
         issue(1'($urandom_range(0, 1)), ra, 8'($urandom), dummy);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      wait_drain();

      // Stuck-at-0 read path during a write of all ones
      stuck0 = 1'b1;
      issue(1'b1, 11'h055, 8'hFF, dummy);
      wait_drain();
      stuck0 = 1'b0;
      check("verify_err", 32'(verify_err), 32'(VERR_EXP));
      issue(1'b1, 11'h056, 8'h3C, dummy);
      wait_drain();
      check("verify_sticky", 32'(verify_err), 32'(VERR_EXP));

      // Reset in the middle of a write strobe
      issue(1'b1, 11'h200, 8'h33, dummy);
      @(negedge clk);
      check("mid_strobe_we", 32'(sram_we_n), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_we_n", 32'(sram_we_n), 32'd1);
      check("async_dout_en", 32'(sram_dout_en), 32'd0);
      check("async_verr", 32'(verify_err), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
